tqvp_bus_initiator: RTL and testbench

- Host-side master for the TinyQV peripheral bus: 6-bit address, 32-bit data, 2-bit write/read size strobes and a data_ready return.
- Takes single requests on a valid/ready command port, drives one bus transaction, and returns the result on a valid/ready response port.
- Read transactions have a timeout.
- Used as a bring-up/debug bridge and as the driving agent in front of peripherals such as the PRISM controller wrapper. Also synchronises and latches the peripheral interrupt line.

---
 rtl/tqvp_bus_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_tqvp_bus_initiator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tqvp_bus_initiator
// Description : Host-side TinyQV peripheral bus master. Accepts one command on
//               a valid/ready port, runs one bus transaction, returns result.
// Revision    : 1.0 - initial release
// ============================================================================
module tqvp_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_write,
    output logic [5:0]  bus_address,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    input  logic        bus_irq,
    input  logic        irq_clear,
    output logic        irq_pending,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]      c_SIZE_ILLEGAL = 2'b11;
    localparam logic [1:0]      c_STROBE_IDLE  = 2'b11;
    localparam logic [TO_W-1:0] c_TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] c_CNT_ONE      = TO_W'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_size;
    logic [1:0]      w_size_nxt;
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic [5:0]      w_addr_nxt;
    logic [31:0]     w_wdata_nxt;
    logic [1:0]      w_write_n_nxt;
    logic [1:0]      w_read_n_nxt;
    logic            w_rsp_valid_nxt;
    logic [31:0]     w_rsp_rdata_nxt;
    logic            w_rsp_error_nxt;
    logic            w_rsp_write_nxt;

    logic            r_irq_meta;
    logic            r_irq_sync;
    logic            r_irq_prev;
    logic            w_irq_rise;

    function automatic logic [31:0] f_zext(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] v;
        case (size)
            2'b00:   v = {24'b0, data[7:0]};
            2'b01:   v = {16'b0, data[15:0]};
            default: v = data;
        endcase
        return v;
    endfunction

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt     = r_state;
        w_size_nxt      = r_size;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = bus_address;
        w_wdata_nxt     = bus_wdata;
        w_write_n_nxt   = c_STROBE_IDLE;
        w_read_n_nxt    = c_STROBE_IDLE;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = rsp_rdata;
        w_rsp_error_nxt = rsp_error;
        w_rsp_write_nxt = rsp_write;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_addr_nxt      = req_addr;
                    w_wdata_nxt     = req_wdata;
                    w_size_nxt      = req_size;
                    w_rsp_write_nxt = req_write;
                    // Illegal sizes never touch the bus.
                    if (req_size == c_SIZE_ILLEGAL) begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_error_nxt = 1'b1;
                        w_rsp_rdata_nxt = 32'b0;
                    end else if (req_write) begin
                        w_state_nxt   = ST_WRITE;
                        w_write_n_nxt = req_size;
                    end else begin
                        w_state_nxt  = ST_READ;
                        w_read_n_nxt = req_size;
                        w_cnt_nxt    = '0;
                    end
                end
            end
            ST_WRITE: begin
                w_state_nxt     = ST_RESP;
                w_rsp_error_nxt = 1'b0;
                w_rsp_rdata_nxt = 32'b0;
            end
            ST_READ: begin
                if (bus_ready) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_rdata_nxt = f_zext(r_size, bus_rdata);
                    w_rsp_error_nxt = 1'b0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_rdata_nxt = 32'b0;
                    w_rsp_error_nxt = 1'b1;
                end else begin
                    w_cnt_nxt    = r_cnt + c_CNT_ONE;
                    w_read_n_nxt = r_size;
                end
            end
            ST_RESP: begin
                // rsp_valid rises one cycle after entering RESP.
                if (rsp_valid && rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_size      <= 2'b00;
            r_cnt       <= '0;
            bus_address <= 6'b0;
            bus_wdata   <= 32'b0;
            bus_write_n <= c_STROBE_IDLE;
            bus_read_n  <= c_STROBE_IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'b0;
            rsp_error   <= 1'b0;
            rsp_write   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_size      <= w_size_nxt;
            r_cnt       <= w_cnt_nxt;
            bus_address <= w_addr_nxt;
            bus_wdata   <= w_wdata_nxt;
            bus_write_n <= w_write_n_nxt;
            bus_read_n  <= w_read_n_nxt;
            rsp_valid   <= w_rsp_valid_nxt;
            rsp_rdata   <= w_rsp_rdata_nxt;
            rsp_error   <= w_rsp_error_nxt;
            rsp_write   <= w_rsp_write_nxt;
        end
    end

    assign w_irq_rise = r_irq_sync & ~r_irq_prev;

    // A new edge outranks a simultaneous clear so no interrupt is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_meta  <= 1'b0;
            r_irq_sync  <= 1'b0;
            r_irq_prev  <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            r_irq_meta <= bus_irq;
            r_irq_sync <= r_irq_meta;
            r_irq_prev <= r_irq_sync;
            if (w_irq_rise) begin
                irq_pending <= 1'b1;
            end else if (irq_clear) begin
                irq_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tqvp_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tqvp_bus_initiator
// Description : Directed vector bench for tqvp_bus_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tqvp_bus_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_write;
    logic [5:0]  bus_address;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_write_n;
    logic [1:0]  bus_read_n;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_irq;
    logic        irq_clear;
    logic        irq_pending;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tqvp_bus_initiator #(
        .TIMEOUT_CYCLES(4),
        .TO_W          (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_write  (rsp_write),
        .bus_address(bus_address),
        .bus_wdata  (bus_wdata),
        .bus_write_n(bus_write_n),
        .bus_read_n (bus_read_n),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .bus_irq    (bus_irq),
        .irq_clear  (irq_clear),
        .irq_pending(irq_pending),
        .busy       (busy)
    );

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_c;      // READ cycles with bus_ready low before it rises
        int          hold;        // cycles rsp_ready is held low once rsp_valid is up
        logic [31:0] exp_rdata;
        logic        exp_error;
        int          exp_strobes;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge while idle; returns at a negedge after the handshake.
    task automatic run_vec(input vec_t v);
        logic [1:0] exp_w;
        logic [1:0] exp_r;
        bit         seen;
        check("req_ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_write = v.write;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        bus_rdata = v.rdata;
        bus_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                check("rsp_latency", c, v.exp_strobes + 1);
            end else begin
                exp_w = (v.write  && c < v.exp_strobes) ? v.size : 2'b11;
                exp_r = (!v.write && c < v.exp_strobes) ? v.size : 2'b11;
                check("strobes", {bus_write_n, bus_read_n}, {exp_w, exp_r});
                if (c == 0) begin
                    check("bus_address", bus_address, v.addr);
                    check("bus_wdata", bus_wdata, v.wdata);
                end
                bus_ready = (c >= v.wait_c);
                @(negedge clk);
            end
        end
        if (!seen) begin
            check("rsp_valid_timeout", 0, 1);
        end
        bus_ready = 1'b0;
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_error", rsp_error, v.exp_error);
        check("rsp_write", rsp_write, v.write);
        check("req_ready_busy_in_resp", {req_ready, busy}, 2'b01);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("rsp_hold_stable",
                  {rsp_valid, req_ready, rsp_rdata, rsp_error, rsp_write, bus_write_n, bus_read_n},
                  {1'b1, 1'b0, v.exp_rdata, v.exp_error, v.write, 4'b1111});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("after_handshake", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        vecs[0] = '{write:1'b1, size:2'b10, addr:6'h00, wdata:32'hA000_0000, rdata:32'h0,
                    wait_c:0, hold:0, exp_rdata:32'h0, exp_error:1'b0, exp_strobes:1};
        vecs[1] = '{write:1'b0, size:2'b00, addr:6'h18, wdata:32'h0, rdata:32'h1234_56F7,
                    wait_c:0, hold:0, exp_rdata:32'h0000_00F7, exp_error:1'b0, exp_strobes:1};
        vecs[2] = '{write:1'b0, size:2'b01, addr:6'h18, wdata:32'h0, rdata:32'h1234_56F7,
                    wait_c:0, hold:0, exp_rdata:32'h0000_56F7, exp_error:1'b0, exp_strobes:1};
        vecs[3] = '{write:1'b0, size:2'b10, addr:6'h04, wdata:32'h0, rdata:32'hDEAD_BEEF,
                    wait_c:3, hold:0, exp_rdata:32'hDEAD_BEEF, exp_error:1'b0, exp_strobes:4};
        vecs[4] = '{write:1'b0, size:2'b10, addr:6'h08, wdata:32'h0, rdata:32'hDEAD_BEEF,
                    wait_c:99, hold:0, exp_rdata:32'h0, exp_error:1'b1, exp_strobes:4};
        vecs[5] = '{write:1'b1, size:2'b11, addr:6'h05, wdata:32'h1111_2222, rdata:32'h0,
                    wait_c:0, hold:5, exp_rdata:32'h0, exp_error:1'b1, exp_strobes:0};
        vecs[6] = '{write:1'b1, size:2'b00, addr:6'h3F, wdata:32'h0000_0055, rdata:32'h0,
                    wait_c:0, hold:1, exp_rdata:32'h0, exp_error:1'b0, exp_strobes:1};
        vecs[7] = '{write:1'b0, size:2'b00, addr:6'h21, wdata:32'h0000_0055, rdata:32'hFFFF_FF80,
                    wait_c:2, hold:0, exp_rdata:32'h0000_0080, exp_error:1'b0, exp_strobes:3};
        vecs[8] = '{write:1'b0, size:2'b11, addr:6'h11, wdata:32'h0000_0055, rdata:32'hFFFF_FFFF,
                    wait_c:0, hold:0, exp_rdata:32'h0, exp_error:1'b1, exp_strobes:0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 6'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        bus_rdata = 32'h0;
        bus_ready = 1'b0;
        bus_irq   = 1'b0;
        irq_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready_busy", {req_ready, busy}, 2'b10);
        check("reset_strobes", {bus_write_n, bus_read_n}, 4'b1111);
        check("reset_bus_addr_data", {bus_address, bus_wdata}, 38'h0);
        check("reset_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_write}, 35'h0);
        check("reset_irq", irq_pending, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // IRQ: 3-cycle pulse, pending appears on the third edge after the rise.
        bus_irq = 1'b1;
        @(negedge clk);
        check("irq_edge1", irq_pending, 0);
        @(negedge clk);
        check("irq_edge2", irq_pending, 0);
        @(negedge clk);
        check("irq_edge3", irq_pending, 1);
        bus_irq = 1'b0;
        repeat (2) @(negedge clk);
        check("irq_sticky", irq_pending, 1);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("irq_cleared", irq_pending, 0);
        repeat (4) @(negedge clk);

        // Clear during the edge-detect cycle: set must win.
        bus_irq = 1'b1;
        repeat (2) @(negedge clk);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("irq_set_wins", irq_pending, 1);
        bus_irq = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a stalled read.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 6'h2A;
        bus_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("read_strobe_before_rst", {bus_write_n, bus_read_n}, 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        check("rst_strobes_immediate", {bus_write_n, bus_read_n}, 4'b1111);
        check("rst_state", {req_ready, busy, irq_pending}, 3'b100);
        check("rst_bus_address", bus_address, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        rsp_ready = 1'b0;
        check("no_rsp_after_abort", bad, 0);

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
